// File: rtl/ws2812b_tx_if.sv
// ws2812b_tx_if: pixel offer handshake between the TinyQV front-end and the line encoder
interface ws2812b_tx_if;
    logic [23:0] data_in;
    logic        valid;
    logic        latch;
    logic        ready;
    modport master (output data_in, valid, latch, input ready);
    modport slave (input data_in, valid, latch, output ready);
endinterface

// File: rtl/ws2812b_tx.sv
// ws2812b_tx: serialises 24-bit GRB pixels MSB-first as WS2812B NRZ pulses with optional strip latch
module ws2812b_tx #(
    parameter int T0H  = 26,
    parameter int T1H  = 51,
    parameter int TBIT = 80,
    parameter int TRES = 19200
) (
    input  logic         clk,
    input  logic         rst_n,
    ws2812b_tx_if.slave  bus,
    output logic         led
);
    typedef enum logic [1:0] {IDLE, BIT, RESET} state_t;
    localparam logic [14:0] HI0_END = 15'(T0H - 1);
    localparam logic [14:0] HI1_END = 15'(T1H - 1);
    localparam logic [14:0] BIT_END = 15'(TBIT - 1);
    localparam logic [14:0] RES_END = 15'(TRES - 1);
    state_t      state, state_n;
    logic [23:0] buf_data, buf_data_n, sh_data, sh_data_n;
    logic        buf_latch, buf_latch_n, buf_full, buf_full_n;
    logic        sh_latch, sh_latch_n, latch_pending, latch_pending_n;
    logic        led_n, ready, ready_n, load, accept;
    logic [4:0]  bit_idx, bit_idx_n;
    logic [14:0] tick, tick_n;
    assign bus.ready = ready;
    assign accept = bus.valid && ready;
    always_comb begin
        state_n = state;
        buf_data_n = buf_data;
        buf_latch_n = buf_latch;
        buf_full_n = buf_full;
        sh_data_n = sh_data;
        sh_latch_n = sh_latch;
        latch_pending_n = latch_pending;
        bit_idx_n = bit_idx;
        tick_n = tick;
        led_n = led;
        load = 1'b0;
        case (state)
            IDLE: begin
                led_n = 1'b0;
                load = buf_full;
            end
            BIT: begin
                tick_n = tick + 15'd1;
                if (tick == (sh_data[23] ? HI1_END : HI0_END)) led_n = 1'b0;
                if (tick == BIT_END) begin
                    if (bit_idx != 5'd23) begin
                        sh_data_n = {sh_data[22:0], 1'b0};
                        bit_idx_n = bit_idx + 5'd1;
                        tick_n = 15'd0;
                        led_n = 1'b1;
                    end else if (sh_latch) begin
                        tick_n = 15'd0;
                        state_n = RESET;
                    end else if (buf_full) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RESET: begin
                led_n = 1'b0;
                tick_n = tick + 15'd1;
                if (tick == RES_END) begin
                    latch_pending_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            sh_data_n = buf_data;
            sh_latch_n = buf_latch;
            buf_full_n = 1'b0;
            bit_idx_n = 5'd0;
            tick_n = 15'd0;
            led_n = 1'b1;
            state_n = BIT;
        end
        // ready is low while buffered, so accept never coincides with load
        if (accept) begin
            buf_data_n = bus.data_in;
            buf_latch_n = bus.latch;
            buf_full_n = 1'b1;
            latch_pending_n = latch_pending || bus.latch;
        end
        ready_n = !buf_full_n && !latch_pending_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            buf_data <= '0;
            buf_latch <= 1'b0;
            buf_full <= 1'b0;
            sh_data <= '0;
            sh_latch <= 1'b0;
            latch_pending <= 1'b0;
            bit_idx <= '0;
            tick <= '0;
            led <= 1'b0;
            ready <= 1'b1;
        end else begin
            state <= state_n;
            buf_data <= buf_data_n;
            buf_latch <= buf_latch_n;
            buf_full <= buf_full_n;
            sh_data <= sh_data_n;
            sh_latch <= sh_latch_n;
            latch_pending <= latch_pending_n;
            bit_idx <= bit_idx_n;
            tick <= tick_n;
            led <= led_n;
            ready <= ready_n;
        end
    end
endmodule

// File: doc/ws2812b_tx.md
# ws2812b_tx

Single-wire WS2812B line encoder that sits directly downstream of the TinyQV WS2812B peripheral front-end. It accepts 24-bit GRB pixels over a one-cycle valid/ready handshake and serialises them MSB-first as WS2812B NRZ pulses on one output pin. A one-entry holding buffer keeps consecutive pixels gap-free. An optional latch flag per pixel appends the strip reset (low) period.

## Interface
- T0H, default 26: cycles led is high for a 0 bit (0.41 µs at 64 MHz).
- T1H, default 51: cycles led is high for a 1 bit (0.80 µs).
- TBIT, default 80: total cycles per bit (1.25 µs). Required: 0 < T0H < T1H < TBIT.
- TRES, default 19200: cycles of low time for latch/reset (300 µs). Must be < 2^15.
- clk  in  1  system clock, 64 MHz nominal.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  24  pixel, [23:16]=G, [15:8]=R, [7:0]=B; sampled only on an accepted handshake.
- valid  in  1  pixel offer; accepted on a rising clk edge where valid && ready.
- latch  in  1  sampled with data_in; 1 = emit TRES low period after this pixel.
- ready  out  1  registered; 1 = a pixel can be accepted this cycle.
- led  out  1  registered serial output to the strip.

## Operation
- Storage:
  - Holding buffer: buf_data[23:0], buf_latch, buf_full.
  - Shifter: sh_data[23:0], sh_latch.
  - Counters: bit_idx (5 b, 0..23) and tick (15 b).
  - Flag: latch_pending.
- ready = !buf_full && !latch_pending, registered.
- Accept (valid && ready at an edge):
  - buf_data ← data_in, buf_latch ← latch, buf_full ← 1.
  - If latch = 1, latch_pending ← 1.
  - valid while ready = 0 is ignored with no side effect.
- State machine (IDLE, BIT, RESET):
  - IDLE:
    - led = 0.
    - If buf_full: move buffer into shifter, buf_full ← 0, bit_idx ← 0, tick ← 0, led ← 1, go to BIT.
  - BIT:
    - tick counts 0..TBIT-1.
    - led ← 0 when tick == (sh_data[23]?T1H:T0H)-1.
    - At tick == TBIT-1 with bit_idx < 23: shift sh_data left by 1, bit_idx+1, tick ← 0, led ← 1.
    - At tick == TBIT-1 with bit_idx == 23:
      - If sh_latch: tick ← 0, go to RESET, led stays 0.
      - Else if buf_full: reload from buffer exactly as in IDLE, stay in BIT, led ← 1. The next pixel's bit 0 starts on the following cycle with no gap.
      - Else: go to IDLE.
  - RESET:
    - led = 0 for TRES cycles.
    - At tick == TRES-1: latch_pending ← 0, go to IDLE.
- A latched pixel blocks further acceptance until its RESET completes. The buffer can never hold a pixel queued behind a latch.
- Simultaneous accept and buffer unload in the same cycle is impossible, because ready is low whenever buf_full = 1.
- Reset (async, any state, mid-bit included):
  - led = 0, ready = 1, state = IDLE.
  - buf_full = 0, latch_pending = 0.
  - All counters and data = 0.
  - Any in-flight pixel is discarded.

## Timing
- Accept at edge E:
  - buf_full is 1 after E, and ready reads 0 in the cycle after E.
  - If IDLE: shifter loads at E+1, led is high from E+1, buffer is empty after E+1.
  - ready returns at E+2 unless latch_pending.
- Each bit occupies exactly TBIT cycles:
  - High for T0H or T1H cycles, then low for the remainder.
  - A pixel is 24·TBIT cycles (1920 with defaults).
- Back-to-back pixels (buffer full at end of bit 23): pixel boundaries are exactly TBIT-spaced, with zero extra cycles.
- Latched pixel:
  - led low for exactly TRES cycles after the last bit period.
  - ready rises one edge after RESET exits.
- Upstream protocol: a one-cycle valid pulse per pixel; valid is re-offered only after ready has been seen low and then high again.

## Test plan
- Reset:
  - Hold rst_n low, then release.
  - → led = 0, ready = 1.
  - Assert rst_n low mid-bit of a 0xFFFFFF pixel → led and ready reach their reset values without waiting for a clock edge.
- Single pixel 0x800001, latch = 0:
  - → 24 pulses at 80-cycle spacing.
  - High widths: bit 0 = 51, bits 1–22 = 26, bit 23 = 51.
  - Then IDLE with led low and ready = 1.
- Back-to-back 0xFF0000 then 0x00FF00:
  - Second pixel offered while the first is shifting.
  - → 48 contiguous bit periods, no gap at the boundary.
  - ready low from second accept until first pixel's bit 23 ends.
- Latch: pixel 0xAAAAAA with latch = 1:
  - → alternating 51/26 high widths, then led low for exactly 19200 cycles.
  - ready = 0 throughout; ready = 1 after RESET.
  - A valid pulse during RESET is ignored (no later output).
- Valid while not ready:
  - Pulse valid with 0x123456 while buf_full = 1.
  - → not captured; the buffered pixel is transmitted unchanged.
- Parameter override T0H = 2, T1H = 4, TBIT = 6, TRES = 10, pixel 0x000001 with latch = 1:
  - → 23 pulses of width 2, one pulse of width 4, each bit period 6 cycles.
  - Then 10 low cycles, then ready = 1.
